// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control unit.
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB)
// and drives datapath enables and selects combinationally from the current
// state, the opcode held in the external IR and the memory handshake.
// An unknown opcode or a memory that stays silent for too long parks the
// FSM in TRAP with a sticky fault, and only reset leaves TRAP.
// Every control output is forced low while reset is held.
module rv32i_mc_ctrl #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instret
);

    // FSM state encodings (also exported on the debug port)
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Immediate format selects
    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_SB = 3'd2;
    localparam logic [2:0] IMM_UJ = 3'd3;
    localparam logic [2:0] IMM_U  = 3'd4;

    // Next-PC sources
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    // Write-back sources
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // The counter holds the number of silent cycles already spent; the
    // cycle in which it equals WAIT_LIMIT-1 is the last one allowed.
    localparam int             CNT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic [31:0]      instret_q, instret_d;

    // Opcode classification
    logic       is_legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_op;
    logic       is_auipc;
    logic [2:0] imm_dec;

    // Ungated control values for the current cycle
    logic       mem_req_c;
    logic       mem_we_c;
    logic       ir_we_c;
    logic       pc_we_c;
    logic       reg_we_c;
    logic [1:0] pc_sel_c;
    logic [2:0] imm_sel_c;
    logic       alu_a_sel_c;
    logic       alu_b_sel_c;
    logic [1:0] wb_sel_c;

    // Memory gave up: still no mem_ready in the last permitted wait cycle
    logic       wait_expired;

    // Classify the opcode and pick its immediate format
    always_comb begin
        is_legal  = 1'b1;
        is_load   = (opcode == OPC_LOAD);
        is_store  = (opcode == OPC_STORE);
        is_branch = (opcode == OPC_BRANCH);
        is_jal    = (opcode == OPC_JAL);
        is_jalr   = (opcode == OPC_JALR);
        is_op     = (opcode == OPC_OP);
        is_auipc  = (opcode == OPC_AUIPC);
        imm_dec   = IMM_I;
        case (opcode)
            OPC_LUI, OPC_AUIPC:            imm_dec = IMM_U;
            OPC_JAL:                       imm_dec = IMM_UJ;
            OPC_BRANCH:                    imm_dec = IMM_SB;
            OPC_STORE:                     imm_dec = IMM_S;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: imm_dec = IMM_I;
            OPC_OP:                        imm_dec = IMM_I;
            default: begin
                imm_dec  = IMM_I;
                is_legal = 1'b0;
            end
        endcase
    end

    assign wait_expired = (wait_cnt_q == WAIT_LAST) && !mem_ready;

    // Next-state, wait counter, fault and per-state control outputs
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        fault_d     = fault_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        reg_we_c    = 1'b0;
        pc_sel_c    = PC_PLUS4;
        imm_sel_c   = IMM_I;
        alu_a_sel_c = 1'b0;
        alu_b_sel_c = 1'b0;
        wb_sel_c    = WB_ALU;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                imm_sel_c = imm_dec;
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    fault_d = 1'b1;
                end
            end

            S_EXEC: begin
                imm_sel_c   = imm_dec;
                alu_a_sel_c = is_auipc || is_jal || is_branch;
                alu_b_sel_c = !is_op;
                if (is_branch) begin
                    // Branches finish here: the compare result picks the PC
                    pc_we_c  = 1'b1;
                    pc_sel_c = br_taken ? PC_REL : PC_PLUS4;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = is_store;
                imm_sel_c = imm_dec;
                if (mem_ready) begin
                    if (is_store) begin
                        // Stores have nothing to write back
                        pc_we_c  = 1'b1;
                        pc_sel_c = PC_PLUS4;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_WB: begin
                imm_sel_c = imm_dec;
                reg_we_c  = 1'b1;
                pc_we_c   = 1'b1;
                if (is_load) begin
                    wb_sel_c = WB_MEM;
                end else if (is_jal || is_jalr) begin
                    wb_sel_c = WB_PC4;
                end else begin
                    wb_sel_c = WB_ALU;
                end
                if (is_jal) begin
                    pc_sel_c = PC_REL;
                end else if (is_jalr) begin
                    pc_sel_c = PC_JALR;
                end else begin
                    pc_sel_c = PC_PLUS4;
                end
                state_d = S_FETCH;
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                // Unused encodings are treated as a corrupted FSM
                state_d = S_TRAP;
                fault_d = 1'b1;
            end
        endcase
    end

    // A retirement is exactly a cycle that writes the PC; TRAP never writes it
    assign instret_d = pc_we_c ? (instret_q + 32'd1) : instret_q;

    // State, wait counter, sticky fault and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            instret_q  <= instret_d;
        end
    end

    // Reset masks every control output at once, so an instruction aborted
    // by reset never leaves a stray write or request behind.
    assign mem_req   = rst_n & mem_req_c;
    assign mem_we    = rst_n & mem_we_c;
    assign ir_we     = rst_n & ir_we_c;
    assign pc_we     = rst_n & pc_we_c;
    assign reg_we    = rst_n & reg_we_c;
    assign pc_sel    = rst_n ? pc_sel_c : PC_PLUS4;
    assign imm_sel   = rst_n ? imm_sel_c : IMM_I;
    assign alu_a_sel = rst_n & alu_a_sel_c;
    assign alu_b_sel = rst_n & alu_b_sel_c;
    assign wb_sel    = rst_n ? wb_sel_c : WB_ALU;

    assign state     = state_q;
    assign fault     = fault_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Testbench for rv32i_mc_ctrl: directed instruction table, hand-built
// timeout / reset sequences and random instruction streams, all compared
// cycle by cycle against an instruction-level trace model.
module tb_rv32i_mc_ctrl;

    localparam int WL = 16;

    localparam int K_ALU  = 0;
    localparam int K_JAL  = 1;
    localparam int K_JALR = 2;
    localparam int K_BR   = 3;
    localparam int K_LD   = 4;
    localparam int K_ST   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instret;

    rv32i_mc_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .pc_sel    (pc_sel),
        .imm_sel   (imm_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .wb_sel    (wb_sel),
        .state     (state),
        .fault     (fault),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq;
        logic       mwe;
        logic       irwe;
        logic       pcwe;
        logic       rgwe;
        logic [1:0] pcs;
        logic [2:0] imm;
        logic       asel;
        logic       bsel;
        logic [1:0] wbs;
        logic       flt;
    } obs_t;

    typedef struct {
        logic mr;
        obs_t exp;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         fw;
        int         mw;
        int         cyc;
        logic [1:0] pcs;
        logic [1:0] wbs;
        logic [2:0] imm;
        logic       rwe;
        logic       flt;
    } vec_t;

    int          check_cnt = 0;
    int          pass_cnt = 0;
    logic [31:0] model_instret = 32'd0;
    step_t       trace[$];
    logic [6:0]  legal_ops[9] = '{7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0000011,
                                  7'b0100011, 7'b0010011, 7'b0110011};

    function automatic obs_t sample_dut();
        obs_t o;
        o.st   = state;
        o.mreq = mem_req;
        o.mwe  = mem_we;
        o.irwe = ir_we;
        o.pcwe = pc_we;
        o.rgwe = reg_we;
        o.pcs  = pc_sel;
        o.imm  = imm_sel;
        o.asel = alu_a_sel;
        o.bsel = alu_b_sel;
        o.wbs  = wb_sel;
        o.flt  = fault;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        check_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    endtask

    // Per-opcode properties straight from the ISA encoding table
    task automatic op_props(input logic [6:0] op, output bit legal, output int kind,
                            output logic [2:0] imm, output logic a, output logic b);
        legal = 1'b1; kind = K_ALU; imm = 3'd0; a = 1'b0; b = 1'b1;
        case (op)
            7'b0110111: imm = 3'd4;
            7'b0010111: begin imm = 3'd4; a = 1'b1; end
            7'b1101111: begin imm = 3'd3; a = 1'b1; kind = K_JAL; end
            7'b1100111: kind = K_JALR;
            7'b1100011: begin imm = 3'd2; a = 1'b1; kind = K_BR; end
            7'b0000011: kind = K_LD;
            7'b0100011: begin imm = 3'd1; kind = K_ST; end
            7'b0010011: kind = K_ALU;
            7'b0110011: b = 1'b0;
            default:    legal = 1'b0;
        endcase
    endtask

    task automatic push(input logic mr, input obs_t o);
        step_t s;
        s.mr  = mr;
        s.exp = o;
        trace.push_back(s);
    endtask

    task automatic push_trap();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            o = '0; o.st = 3'd5; o.flt = 1'b1;
            push(1'($urandom_range(0, 1)), o);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one instruction: fw silent fetch
    // cycles, mw silent memory cycles; WL or more silent cycles means a trap.
    task automatic build_trace(input logic [6:0] op, input logic bt, input int fw, input int mw);
        bit legal; int kind; logic [2:0] imm; logic a, b;
        obs_t o;
        trace.delete();
        op_props(op, legal, kind, imm, a, b);
        for (int i = 0; i < fw && i < WL; i++) begin
            o = '0; o.st = 3'd0; o.mreq = 1'b1;
            push(1'b0, o);
        end
        if (fw >= WL) begin push_trap(); return; end
        o = '0; o.st = 3'd0; o.mreq = 1'b1; o.irwe = 1'b1;
        push(1'b1, o);
        o = '0; o.st = 3'd1; o.imm = imm;
        push(1'($urandom_range(0, 1)), o);
        if (!legal) begin push_trap(); return; end
        o = '0; o.st = 3'd2; o.imm = imm; o.asel = a; o.bsel = b;
        if (kind == K_BR) begin o.pcwe = 1'b1; o.pcs = bt ? 2'd1 : 2'd0; end
        push(1'($urandom_range(0, 1)), o);
        if (kind == K_BR) return;
        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i < mw && i < WL; i++) begin
                o = '0; o.st = 3'd3; o.mreq = 1'b1; o.mwe = (kind == K_ST); o.imm = imm;
                push(1'b0, o);
            end
            if (mw >= WL) begin push_trap(); return; end
            o = '0; o.st = 3'd3; o.mreq = 1'b1; o.mwe = (kind == K_ST); o.imm = imm;
            o.pcwe = (kind == K_ST);
            push(1'b1, o);
            if (kind == K_ST) return;
        end
        o = '0; o.st = 3'd4; o.imm = imm; o.rgwe = 1'b1; o.pcwe = 1'b1;
        o.wbs = (kind == K_LD) ? 2'd1 : ((kind == K_JAL || kind == K_JALR) ? 2'd2 : 2'd0);
        o.pcs = (kind == K_JAL) ? 2'd1 : ((kind == K_JALR) ? 2'd2 : 2'd0);
        push(1'($urandom_range(0, 1)), o);
    endtask

    // Drive one instruction from posedge+1 and compare every cycle
    task automatic run_instr(input logic [6:0] op, input logic bt, input int fw, input int mw,
                             output int rcyc, output obs_t robs);
        obs_t act;
        build_trace(op, bt, fw, mw);
        rcyc = 0;
        robs = '0;
        foreach (trace[i]) begin
            opcode    = (trace[i].exp.st == 3'd0) ? 7'($urandom) : op;
            br_taken  = (trace[i].exp.st == 3'd2) ? bt : 1'($urandom_range(0, 1));
            mem_ready = trace[i].mr;
            @(negedge clk);
            act = sample_dut();
            check("trace", 32'(act), 32'(trace[i].exp));
            if (trace[i].exp.pcwe) model_instret = model_instret + 32'd1;
            if (act.pcwe && rcyc == 0) begin
                rcyc = i + 1;
                robs = act;
            end
            @(posedge clk);
            #1;
        end
        check("instret", instret, model_instret);
        $display("instr op=%b bt=%0d fw=%0d mw=%0d retire_cycle=%0d instret=%0d",
                 op, bt, fw, mw, rcyc, instret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset_outputs", 32'(sample_dut()), 32'd0);
        check("reset_instret", instret, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", 32'(sample_dut()), 32'd0);
        rst_n = 1'b1;
        model_instret = 32'd0;
    endtask

    initial begin
        vec_t vt[16];
        int   rcyc;
        obs_t robs;
        obs_t o;

        //            op          bt    fw  mw  cyc pcs   wbs   imm   rwe   flt
        vt[0]  = '{7'b0010011, 1'b0, 0,  0,  4,  2'd0, 2'd0, 3'd0, 1'b1, 1'b0};
        vt[1]  = '{7'b1100011, 1'b1, 0,  0,  3,  2'd1, 2'd0, 3'd2, 1'b0, 1'b0};
        vt[2]  = '{7'b1100011, 1'b0, 0,  0,  3,  2'd0, 2'd0, 3'd2, 1'b0, 1'b0};
        vt[3]  = '{7'b0000011, 1'b0, 0,  3,  8,  2'd0, 2'd1, 3'd0, 1'b1, 1'b0};
        vt[4]  = '{7'b0100011, 1'b0, 0,  0,  4,  2'd0, 2'd0, 3'd1, 1'b0, 1'b0};
        vt[5]  = '{7'b1100111, 1'b0, 0,  0,  4,  2'd2, 2'd2, 3'd0, 1'b1, 1'b0};
        vt[6]  = '{7'b1101111, 1'b0, 0,  0,  4,  2'd1, 2'd2, 3'd3, 1'b1, 1'b0};
        vt[7]  = '{7'b0110111, 1'b0, 0,  0,  4,  2'd0, 2'd0, 3'd4, 1'b1, 1'b0};
        vt[8]  = '{7'b0010111, 1'b0, 0,  0,  4,  2'd0, 2'd0, 3'd4, 1'b1, 1'b0};
        vt[9]  = '{7'b0110011, 1'b0, 0,  0,  4,  2'd0, 2'd0, 3'd0, 1'b1, 1'b0};
        vt[10] = '{7'b0010011, 1'b0, 15, 0,  19, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0};
        vt[11] = '{7'b0100011, 1'b0, 0,  15, 19, 2'd0, 2'd0, 3'd1, 1'b0, 1'b0};
        vt[12] = '{7'b0000011, 1'b0, 2,  15, 22, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0};
        vt[13] = '{7'b1111111, 1'b0, 0,  0,  0,  2'd0, 2'd0, 3'd0, 1'b0, 1'b1};
        vt[14] = '{7'b0010011, 1'b0, 16, 0,  0,  2'd0, 2'd0, 3'd0, 1'b0, 1'b1};
        vt[15] = '{7'b0000011, 1'b0, 0,  16, 0,  2'd0, 2'd0, 3'd0, 1'b0, 1'b1};

        do_reset();

        // Directed instruction table
        for (int r = 0; r < 16; r++) begin
            run_instr(vt[r].op, vt[r].bt, vt[r].fw, vt[r].mw, rcyc, robs);
            check("retire_cycle", 32'(rcyc), 32'(vt[r].cyc));
            if (vt[r].cyc != 0)
                check("retire_fields", 32'({robs.pcs, robs.wbs, robs.imm, robs.rgwe}),
                      32'({vt[r].pcs, vt[r].wbs, vt[r].imm, vt[r].rwe}));
            check("fault_after", 32'(fault), 32'(vt[r].flt));
            if (vt[r].flt) do_reset();
        end

        // Fetch timeout after one retired instruction: instret must not move
        run_instr(7'b0010011, 1'b0, 0, 0, rcyc, robs);
        for (int i = 0; i < WL; i++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            check("fetch_wait", 32'({state, mem_req}), 32'({3'd0, 1'b1}));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("fetch_timeout", 32'({state, fault, mem_req, pc_we}), 32'({3'd5, 1'b1, 1'b0, 1'b0}));
        check("timeout_instret", instret, 32'd1);
        @(posedge clk);
        #1;
        do_reset();

        // Reset pulse in the middle of a load's MEM phase
        run_instr(7'b0010011, 1'b0, 0, 0, rcyc, robs);
        opcode = 7'b0000011;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end
        @(negedge clk);
        check("mem_before_reset", 32'({state, mem_req}), 32'({3'd3, 1'b1}));
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'(sample_dut()), 32'd0);
        check("abort_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_instret = 32'd0;
        @(negedge clk);
        o = '0; o.st = 3'd0; o.mreq = 1'b1;
        check("first_fetch", 32'(sample_dut()), 32'(o));
        check("first_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // Random legal instruction stream
        for (int n = 0; n < 40; n++) begin
            int fw, mw;
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WL - 1)) : 0;
            mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WL - 1)) : 0;
            run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), fw, mw, rcyc, robs);
        end
        check("final_fault", 32'(fault), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
